rvfi_retire_queue: RTL and testbench

Parametrised, synthesizable in-order retirement tracker for RV32 RVFI tracing. Instructions are allocated into a fixed-depth circular buffer at decode and receive a tag. Results arrive later, tagged, from the MEM stage (ALU/store) or the WB stage (loads). Finished entries retire in program order on a registered RVFI port. A MEM-stage redirect squashes all younger wrong-path entries. The block sits beside the core pipeline in the SoC tracer path and drives the RVFI monitor/scoreboard.

---
 rtl/rvfi_pkg.sv | 40 ++++
 rtl/rvfi_retire_queue.sv | 186 ++++++++++++++++++
 tb/tb_rvfi_retire_queue.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvfi_pkg.sv
// rvfi_pkg: entry and retire-bundle types shared by the retire queue, tracer and scoreboard.
// Revision: 1.0
`default_nettype none

package rvfi_pkg;

  localparam int RVFI_XLEN = 32;

  typedef struct packed {
    logic                 valid;
    logic                 done;
    logic                 wait_wb;
    logic [31:0]          insn;
    logic [RVFI_XLEN-1:0] pc_rdata;
    logic [RVFI_XLEN-1:0] pc_wdata;
    logic [RVFI_XLEN-1:0] rd_wdata;
    logic [RVFI_XLEN-1:0] rs1_rdata;
    logic [RVFI_XLEN-1:0] rs2_rdata;
    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic [4:0]           rd_addr;
  } rvfi_entry_t;

  typedef struct packed {
    logic                 valid;
    logic [63:0]          order;
    logic [31:0]          insn;
    logic [RVFI_XLEN-1:0] pc_rdata;
    logic [RVFI_XLEN-1:0] pc_wdata;
    logic [RVFI_XLEN-1:0] rd_wdata;
    logic [RVFI_XLEN-1:0] rs1_rdata;
    logic [RVFI_XLEN-1:0] rs2_rdata;
    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic [4:0]           rd_addr;
  } rvfi_retire_t;

endpackage

`default_nettype wire

// File: rtl/rvfi_retire_queue.sv
// rvfi_retire_queue: in-order retirement tracker driving a registered RVFI port.
// Revision: 1.0
`default_nettype none

module rvfi_retire_queue
  import rvfi_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic [31:0]      alloc_insn,
  input  logic [XLEN-1:0]  alloc_pc,
  input  logic [XLEN-1:0]  alloc_next_pc,
  input  logic [4:0]       alloc_rs1_addr,
  input  logic [4:0]       alloc_rs2_addr,
  input  logic [4:0]       alloc_rd_addr,
  input  logic [XLEN-1:0]  alloc_rs1_rdata,
  input  logic [XLEN-1:0]  alloc_rs2_rdata,
  input  logic             mem_cpl_valid,
  input  logic [TAG_W-1:0] mem_cpl_tag,
  input  logic [XLEN-1:0]  mem_cpl_data,
  input  logic             mem_cpl_is_load,
  input  logic             mem_cpl_redirect,
  input  logic [XLEN-1:0]  mem_cpl_target,
  input  logic             wb_cpl_valid,
  input  logic [TAG_W-1:0] wb_cpl_tag,
  input  logic [XLEN-1:0]  wb_cpl_data,
  output logic             rvfi_valid,
  output logic [63:0]      rvfi_order,
  output logic [31:0]      rvfi_insn,
  output logic [XLEN-1:0]  rvfi_pc_rdata,
  output logic [XLEN-1:0]  rvfi_pc_wdata,
  output logic [XLEN-1:0]  rvfi_rd_wdata,
  output logic [4:0]       rvfi_rs1_addr,
  output logic [4:0]       rvfi_rs2_addr,
  output logic [XLEN-1:0]  rvfi_rs1_rdata,
  output logic [XLEN-1:0]  rvfi_rs2_rdata,
  output logic [4:0]       rvfi_rd_addr,
  output logic [TAG_W:0]   occupancy,
  output logic             protocol_err
);

  localparam logic [TAG_W:0] C_DEPTH = (TAG_W+1)'(DEPTH);

  logic [TAG_W:0]   r_head, r_tail, w_occ, w_head_n, w_tail_n;
  logic [TAG_W-1:0] w_head_idx, w_tail_idx, w_redir_age, w_age;
  rvfi_entry_t      r_ent [DEPTH];
  rvfi_entry_t      w_ent [DEPTH];
  rvfi_entry_t      w_ret_ent;
  rvfi_retire_t     r_out;
  logic [63:0]      r_order;
  logic             r_err;
  logic             w_mem_hit, w_mem_ok, w_wb_ok, w_redirect, w_alloc, w_ret, w_err_set;

  assign w_head_idx  = r_head[TAG_W-1:0];
  assign w_tail_idx  = r_tail[TAG_W-1:0];
  assign w_occ       = r_tail - r_head;
  assign alloc_ready = (w_occ != C_DEPTH);
  assign alloc_tag   = w_tail_idx;
  assign occupancy   = w_occ;

  // A WB to the same tag takes priority; the MEM completion is then dropped silently.
  assign w_mem_hit   = mem_cpl_valid && !(wb_cpl_valid && (wb_cpl_tag == mem_cpl_tag));
  assign w_mem_ok    = w_mem_hit && r_ent[mem_cpl_tag].valid && !r_ent[mem_cpl_tag].done;
  assign w_wb_ok     = wb_cpl_valid && r_ent[wb_cpl_tag].valid && r_ent[wb_cpl_tag].wait_wb;
  assign w_redirect  = w_mem_ok && mem_cpl_redirect;
  assign w_redir_age = mem_cpl_tag - w_head_idx;
  assign w_alloc     = alloc_valid && alloc_ready && !w_redirect;
  assign w_err_set   = (w_mem_hit && !w_mem_ok) || (wb_cpl_valid && !w_wb_ok) ||
                       (alloc_valid && !alloc_ready && !w_redirect);

  always_comb begin
    w_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_ent[i] = r_ent[i];
    end
    if (w_alloc) begin
      w_ent[w_tail_idx].valid     = 1'b1;
      w_ent[w_tail_idx].done      = 1'b0;
      w_ent[w_tail_idx].wait_wb   = 1'b0;
      w_ent[w_tail_idx].insn      = alloc_insn;
      w_ent[w_tail_idx].pc_rdata  = alloc_pc;
      w_ent[w_tail_idx].pc_wdata  = alloc_next_pc;
      w_ent[w_tail_idx].rd_wdata  = '0;
      w_ent[w_tail_idx].rs1_rdata = alloc_rs1_rdata;
      w_ent[w_tail_idx].rs2_rdata = alloc_rs2_rdata;
      w_ent[w_tail_idx].rs1_addr  = alloc_rs1_addr;
      w_ent[w_tail_idx].rs2_addr  = alloc_rs2_addr;
      w_ent[w_tail_idx].rd_addr   = alloc_rd_addr;
    end
    if (w_mem_ok) begin
      if (mem_cpl_is_load) begin
        w_ent[mem_cpl_tag].wait_wb = 1'b1;
      end else begin
        w_ent[mem_cpl_tag].rd_wdata = mem_cpl_data;
        w_ent[mem_cpl_tag].done     = 1'b1;
      end
      if (mem_cpl_redirect) begin
        w_ent[mem_cpl_tag].pc_wdata = mem_cpl_target;
      end
    end
    if (w_wb_ok) begin
      w_ent[wb_cpl_tag].rd_wdata = wb_cpl_data;
      w_ent[wb_cpl_tag].done     = 1'b1;
      w_ent[wb_cpl_tag].wait_wb  = 1'b0;
    end
    // Squash by age relative to head so wrap-around is handled uniformly.
    if (w_redirect) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_age = TAG_W'(i) - w_head_idx;
        if (w_age > w_redir_age) begin
          w_ent[i].valid   = 1'b0;
          w_ent[i].done    = 1'b0;
          w_ent[i].wait_wb = 1'b0;
        end
      end
    end
    w_ret_ent = w_ent[w_head_idx];
    w_ret     = w_ret_ent.valid && w_ret_ent.done;
    if (w_ret) begin
      w_ent[w_head_idx].valid   = 1'b0;
      w_ent[w_head_idx].done    = 1'b0;
      w_ent[w_head_idx].wait_wb = 1'b0;
    end
  end

  assign w_head_n = r_head + {{TAG_W{1'b0}}, w_ret};
  assign w_tail_n = w_redirect ? (r_head + {1'b0, w_redir_age} + {{TAG_W{1'b0}}, 1'b1})
                               : (r_tail + {{TAG_W{1'b0}}, w_alloc});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_order <= '0;
      r_err   <= 1'b0;
      r_out   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= '0;
      end
    end else begin
      r_head      <= w_head_n;
      r_tail      <= w_tail_n;
      r_err       <= r_err | w_err_set;
      r_out.valid <= w_ret;
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= w_ent[i];
      end
      if (w_ret) begin
        r_order         <= r_order + 64'd1;
        r_out.order     <= r_order;
        r_out.insn      <= w_ret_ent.insn;
        r_out.pc_rdata  <= w_ret_ent.pc_rdata;
        r_out.pc_wdata  <= w_ret_ent.pc_wdata;
        r_out.rd_wdata  <= (w_ret_ent.rd_addr == 5'd0) ? '0 : w_ret_ent.rd_wdata;
        r_out.rs1_rdata <= w_ret_ent.rs1_rdata;
        r_out.rs2_rdata <= w_ret_ent.rs2_rdata;
        r_out.rs1_addr  <= w_ret_ent.rs1_addr;
        r_out.rs2_addr  <= w_ret_ent.rs2_addr;
        r_out.rd_addr   <= w_ret_ent.rd_addr;
      end
    end
  end

  assign rvfi_valid     = r_out.valid;
  assign rvfi_order     = r_out.order;
  assign rvfi_insn      = r_out.insn;
  assign rvfi_pc_rdata  = r_out.pc_rdata;
  assign rvfi_pc_wdata  = r_out.pc_wdata;
  assign rvfi_rd_wdata  = r_out.rd_wdata;
  assign rvfi_rs1_addr  = r_out.rs1_addr;
  assign rvfi_rs2_addr  = r_out.rs2_addr;
  assign rvfi_rs1_rdata = r_out.rs1_rdata;
  assign rvfi_rs2_rdata = r_out.rs2_rdata;
  assign rvfi_rd_addr   = r_out.rd_addr;
  assign protocol_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rvfi_retire_queue.sv
// tb_rvfi_retire_queue: directed and random stimulus against a queue-based retirement model.
// Revision: 1.0
`default_nettype none

module tb_rvfi_retire_queue;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int TAG_W = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             alloc_valid, alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic [31:0]      alloc_insn, alloc_pc, alloc_next_pc, alloc_rs1_rdata, alloc_rs2_rdata;
  logic [4:0]       alloc_rs1_addr, alloc_rs2_addr, alloc_rd_addr;
  logic             mem_cpl_valid, mem_cpl_is_load, mem_cpl_redirect;
  logic [TAG_W-1:0] mem_cpl_tag, wb_cpl_tag;
  logic [31:0]      mem_cpl_data, mem_cpl_target, wb_cpl_data;
  logic             wb_cpl_valid;
  logic             rvfi_valid;
  logic [63:0]      rvfi_order;
  logic [31:0]      rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rd_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata;
  logic [4:0]       rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [TAG_W:0]   occupancy;
  logic             protocol_err;

  always #5 clk = ~clk;

  rvfi_retire_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_insn(alloc_insn), .alloc_pc(alloc_pc), .alloc_next_pc(alloc_next_pc),
    .alloc_rs1_addr(alloc_rs1_addr), .alloc_rs2_addr(alloc_rs2_addr), .alloc_rd_addr(alloc_rd_addr),
    .alloc_rs1_rdata(alloc_rs1_rdata), .alloc_rs2_rdata(alloc_rs2_rdata),
    .mem_cpl_valid(mem_cpl_valid), .mem_cpl_tag(mem_cpl_tag), .mem_cpl_data(mem_cpl_data),
    .mem_cpl_is_load(mem_cpl_is_load), .mem_cpl_redirect(mem_cpl_redirect), .mem_cpl_target(mem_cpl_target),
    .wb_cpl_valid(wb_cpl_valid), .wb_cpl_tag(wb_cpl_tag), .wb_cpl_data(wb_cpl_data),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_addr(rvfi_rd_addr),
    .occupancy(occupancy), .protocol_err(protocol_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Reference model: live tags in program order plus per-tag records.
  int          q[$];
  int          m_head;
  logic [63:0] m_order;
  bit          m_done [DEPTH];
  bit          m_wwb  [DEPTH];
  logic [31:0] m_insn [DEPTH], m_pc [DEPTH], m_npc [DEPTH], m_rd [DEPTH], m_r1d [DEPTH], m_r2d [DEPTH];
  logic [4:0]  m_r1a [DEPTH], m_r2a [DEPTH], m_rda [DEPTH];
  logic        e_valid, e_err;
  logic [63:0] e_order;
  logic [31:0] e_insn, e_pc, e_npc, e_rd, e_r1d, e_r2d;
  logic [4:0]  e_r1a, e_r2a, e_rda;

  function automatic int find_pos(input int tag);
    foreach (q[k]) if (q[k] == tag) return k;
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_head = 0; m_order = '0;
    for (int i = 0; i < DEPTH; i++) begin m_done[i] = 0; m_wwb[i] = 0; end
    e_valid = 0; e_err = 0; e_order = '0;
    e_insn = '0; e_pc = '0; e_npc = '0; e_rd = '0; e_r1d = '0; e_r2d = '0;
    e_r1a = '0; e_r2a = '0; e_rda = '0;
  endtask

  task automatic model_step();
    int pm, pw, mt, wt;
    bit mem_hit, mem_ok, wb_ok, redir;
    mt = int'(mem_cpl_tag);
    wt = int'(wb_cpl_tag);
    mem_hit = mem_cpl_valid && !(wb_cpl_valid && mt == wt);
    pm = find_pos(mt);
    pw = find_pos(wt);
    mem_ok = mem_hit && pm >= 0 && !m_done[mt];
    wb_ok  = wb_cpl_valid && pw >= 0 && m_wwb[wt];
    if ((mem_hit && !mem_ok) || (wb_cpl_valid && !wb_ok)) e_err = 1;
    redir = mem_ok && mem_cpl_redirect;
    if (mem_ok) begin
      if (mem_cpl_is_load) m_wwb[mt] = 1;
      else begin m_rd[mt] = mem_cpl_data; m_done[mt] = 1; end
      if (redir) m_npc[mt] = mem_cpl_target;
    end
    if (wb_ok) begin m_rd[wt] = wb_cpl_data; m_done[wt] = 1; m_wwb[wt] = 0; end
    if (redir) q = q[0:pm];
    if (alloc_valid && !redir) begin
      if (q.size() < DEPTH) begin
        int t = (m_head + q.size()) % DEPTH;
        m_done[t] = 0; m_wwb[t] = 0; m_rd[t] = '0;
        m_insn[t] = alloc_insn; m_pc[t] = alloc_pc; m_npc[t] = alloc_next_pc;
        m_r1d[t] = alloc_rs1_rdata; m_r2d[t] = alloc_rs2_rdata;
        m_r1a[t] = alloc_rs1_addr; m_r2a[t] = alloc_rs2_addr; m_rda[t] = alloc_rd_addr;
        q.push_back(t);
      end else e_err = 1;
    end
    e_valid = 0;
    if (q.size() > 0 && m_done[q[0]]) begin
      int t = q.pop_front();
      e_valid = 1; e_order = m_order; m_order = m_order + 1;
      e_insn = m_insn[t]; e_pc = m_pc[t]; e_npc = m_npc[t];
      e_rd = (m_rda[t] == 5'd0) ? 32'd0 : m_rd[t];
      e_r1d = m_r1d[t]; e_r2d = m_r2d[t]; e_r1a = m_r1a[t]; e_r2a = m_r2a[t]; e_rda = m_rda[t];
      m_head = (m_head + 1) % DEPTH;
    end
  endtask

  task automatic check_all();
    check_eq("rvfi_valid", rvfi_valid, e_valid);
    check_eq("rvfi_order", rvfi_order, e_order);
    check_eq("rvfi_insn", rvfi_insn, e_insn);
    check_eq("rvfi_pc_rdata", rvfi_pc_rdata, e_pc);
    check_eq("rvfi_pc_wdata", rvfi_pc_wdata, e_npc);
    check_eq("rvfi_rd_wdata", rvfi_rd_wdata, e_rd);
    check_eq("rvfi_rd_addr", rvfi_rd_addr, e_rda);
    check_eq("rvfi_rs1_addr", rvfi_rs1_addr, e_r1a);
    check_eq("rvfi_rs2_addr", rvfi_rs2_addr, e_r2a);
    check_eq("rvfi_rs1_rdata", rvfi_rs1_rdata, e_r1d);
    check_eq("rvfi_rs2_rdata", rvfi_rs2_rdata, e_r2d);
    check_eq("occupancy", occupancy, q.size());
    check_eq("alloc_ready", alloc_ready, q.size() < DEPTH);
    check_eq("alloc_tag", alloc_tag, (m_head + q.size()) % DEPTH);
    check_eq("protocol_err", protocol_err, e_err);
  endtask

  task automatic idle();
    alloc_valid = 0; mem_cpl_valid = 0; mem_cpl_is_load = 0; mem_cpl_redirect = 0; wb_cpl_valid = 0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    idle();
  endtask

  task automatic set_alloc(input logic [31:0] pc, input logic [4:0] rd);
    alloc_valid = 1; alloc_pc = pc; alloc_next_pc = pc + 32'd4; alloc_insn = $urandom;
    alloc_rd_addr = rd; alloc_rs1_addr = 5'($urandom); alloc_rs2_addr = 5'($urandom);
    alloc_rs1_rdata = $urandom; alloc_rs2_rdata = $urandom;
  endtask

  task automatic set_mem(input int tag, input logic [31:0] data, input bit ld, input bit rd, input logic [31:0] tgt);
    mem_cpl_valid = 1; mem_cpl_tag = TAG_W'(tag); mem_cpl_data = data;
    mem_cpl_is_load = ld; mem_cpl_redirect = rd; mem_cpl_target = tgt;
  endtask

  task automatic alloc1(input logic [31:0] pc, input logic [4:0] rd);
    set_alloc(pc, rd); step();
  endtask

  task automatic mem1(input int tag, input logic [31:0] data, input bit ld, input bit rd, input logic [31:0] tgt);
    set_mem(tag, data, ld, rd, tgt); step();
  endtask

  task automatic wb1(input int tag, input logic [31:0] data);
    wb_cpl_valid = 1; wb_cpl_tag = TAG_W'(tag); wb_cpl_data = data; step();
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() > 0; k++) begin
      int t = q[0];
      if (m_wwb[t]) wb1(t, $urandom);
      else if (!m_done[t]) mem1(t, $urandom, 0, 0, 0);
      else step();
    end
    check_eq("drain_occ", occupancy, 0);
  endtask

  task automatic do_reset_async();
    reset_n = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset_n = 1;
  endtask

  initial begin
    int t;
    idle();
    alloc_insn = '0; alloc_pc = '0; alloc_next_pc = '0; alloc_rs1_rdata = '0; alloc_rs2_rdata = '0;
    alloc_rs1_addr = '0; alloc_rs2_addr = '0; alloc_rd_addr = '0;
    mem_cpl_tag = '0; mem_cpl_data = '0; mem_cpl_target = '0; wb_cpl_tag = '0; wb_cpl_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset_n = 1;

    // In-order completion, back-to-back retire
    alloc1(32'h0, 5'd1); alloc1(32'h4, 5'd2); alloc1(32'h8, 5'd3);
    mem1(0, 32'd5, 0, 0, 0);
    check_eq("t1_valid0", rvfi_valid, 1); check_eq("t1_rd0", rvfi_rd_wdata, 5); check_eq("t1_ord0", rvfi_order, 0);
    mem1(1, 32'd6, 0, 0, 0);
    check_eq("t1_rd1", rvfi_rd_wdata, 6); check_eq("t1_ord1", rvfi_order, 1);
    mem1(2, 32'd7, 0, 0, 0);
    check_eq("t1_rd2", rvfi_rd_wdata, 7); check_eq("t1_ord2", rvfi_order, 2);
    step();
    check_eq("t1_idle", rvfi_valid, 0);

    // Out-of-order completion waits for the older entry
    t = int'(alloc_tag);
    alloc1(32'h10, 5'd4); alloc1(32'h14, 5'd5);
    mem1((t + 1) % DEPTH, 32'h11, 0, 0, 0);
    check_eq("t2_hold", rvfi_valid, 0);
    step();
    mem1(t, 32'h10, 0, 0, 0);
    check_eq("t2_pc0", rvfi_pc_rdata, 32'h10);
    step();
    check_eq("t2_pc1", rvfi_pc_rdata, 32'h14); check_eq("t2_v1", rvfi_valid, 1);

    // Load completes at WB
    t = int'(alloc_tag);
    alloc1(32'h20, 5'd6);
    mem1(t, 32'h0, 1, 0, 0);
    step();
    check_eq("t3_hold", rvfi_valid, 0);
    wb1(t, 32'hDEADBEEF);
    check_eq("t3_rd", rvfi_rd_wdata, 32'hDEADBEEF);

    // Redirect squashes younger entries
    t = int'(alloc_tag);
    alloc1(32'h100, 5'd7); alloc1(32'h104, 5'd8); alloc1(32'h108, 5'd9); alloc1(32'h10C, 5'd10);
    mem1((t + 1) % DEPTH, 32'h55, 0, 1, 32'h40);
    check_eq("t4_occ", occupancy, 2); check_eq("t4_tag", alloc_tag, (t + 2) % DEPTH);
    mem1(t, 32'h44, 0, 0, 0);
    step();
    check_eq("t4_npc", rvfi_pc_wdata, 32'h40);

    // Full buffer, overflow error, retire-vs-alloc at full
    drain();
    t = int'(alloc_tag);
    for (int i = 0; i < DEPTH; i++) alloc1(32'h200 + 32'(i * 4), 5'(i));
    check_eq("t5_full", alloc_ready, 0);
    alloc1(32'h300, 5'd1);
    check_eq("t5_err", protocol_err, 1);
    set_alloc(32'h304, 5'd2);
    set_mem(t, 32'h77, 0, 0, 0);
    step();
    check_eq("t5_occ", occupancy, DEPTH - 1); check_eq("t5_ready", alloc_ready, 1);
    check_eq("t5_wrap", alloc_tag, t);

    // Asynchronous reset with live entries, then a stale completion
    drain();
    do_reset_async();
    for (int i = 0; i < 5; i++) alloc1(32'h400 + 32'(i * 4), 5'd3);
    do_reset_async();
    check_eq("t6_occ", occupancy, 0);
    mem1(2, 32'h1, 0, 0, 0);
    check_eq("t6_stale_err", protocol_err, 1);
    do_reset_async();

    // Randomised traffic
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 2) != 0) set_alloc($urandom, 5'($urandom_range(0, 3) == 0 ? 0 : $urandom));
      if ($urandom_range(0, 1) == 0) begin
        int mt = (q.size() > 0 && $urandom_range(0, 7) != 0) ? q[$urandom_range(0, q.size() - 1)]
                                                             : int'($urandom_range(0, DEPTH - 1));
        set_mem(mt, $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        int cand[$];
        foreach (q[k]) if (m_wwb[q[k]]) cand.push_back(q[k]);
        if (cand.size() > 0 && $urandom_range(0, 7) != 0) begin
          wb_cpl_valid = 1; wb_cpl_tag = TAG_W'(cand[$urandom_range(0, cand.size() - 1)]);
        end else begin
          wb_cpl_valid = 1; wb_cpl_tag = TAG_W'($urandom);
        end
        wb_cpl_data = $urandom;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
